uart_rx_engine: RTL and testbench

- Serial receive front end of the full UART.
- Oversamples the asynchronous RX line, frames start/data/parity/stop, and assembles one 8-bit character.
- Emits a one-cycle rx_done strobe that drives the load input of the downstream 8-bit receive holding register; rx_data feeds that register's D input.
- Also reports per-frame parity and framing status to the status logic.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_engine_if.sv | 30 +++
 rtl/uart_bit_timer.sv | 40 ++++
 rtl/uart_rx_engine.sv | 156 +++++++++++++++
 tb/tb_uart_rx_engine.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_pkg                                                      |
// | Brief    : Shared UART types and constants used by the RX and TX engines |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int BIT_TIME_DEFAULT = 5208;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    WAIT_HI = 3'd5
  } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_engine_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_rx_engine_if                                             |
// | Brief    : Serial line, configuration and receive status bundle          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface uart_rx_engine_if;
  import uart_pkg::*;

  logic                 rx;
  logic                 pen;
  logic                 odd;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_done;
  logic                 perr;
  logic                 ferr;
  logic                 busy;

  modport master (
    input  rx, pen, odd,
    output rx_data, rx_done, perr, ferr, busy
  );

  modport slave (
    output rx, pen, odd,
    input  rx_data, rx_done, perr, ferr, busy
  );

endinterface
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_bit_timer                                                |
// | Brief    : Reloading bit-time down-counter with half/full load and tick  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_bit_timer #(
  parameter int BIT_TIME = uart_pkg::BIT_TIME_DEFAULT,
  parameter int CNT_W    = 16
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic load,
  input  wire logic half,
  output logic      tick
);

  localparam logic [CNT_W-1:0] c_full = CNT_W'(BIT_TIME - 1);
  localparam logic [CNT_W-1:0] c_half = CNT_W'(BIT_TIME / 2 - 1);
  localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

  logic [CNT_W-1:0] r_bit_cnt;

  // Free-running between loads: every zero is a tick and reloads a full bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= '0;
    end else if (load) begin
      r_bit_cnt <= half ? c_half : c_full;
    end else if (r_bit_cnt == '0) begin
      r_bit_cnt <= c_full;
    end else begin
      r_bit_cnt <= r_bit_cnt - c_one;
    end
  end

  assign tick = (r_bit_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/uart_rx_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_rx_engine                                                |
// | Brief    : Oversampling UART receiver with parity and framing status     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_rx_engine #(
  parameter int BIT_TIME = uart_pkg::BIT_TIME_DEFAULT,
  parameter int CNT_W    = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  uart_rx_engine_if.master  bus
);
  import uart_pkg::*;

  localparam logic [2:0] c_last_idx = 3'(DATA_BITS - 1);
  localparam logic [2:0] c_idx_one  = 3'd1;

  logic                 r_sync1;
  logic                 r_rxs;
  uart_state_e          r_state;
  uart_state_e          w_next;
  logic                 w_tick;
  logic                 w_load;
  logic                 w_clr_idx;
  logic                 w_shift;
  logic                 w_cap_par;
  logic                 w_finish;
  logic [2:0]           r_idx;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 r_pbit;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_done;
  logic                 r_perr;
  logic                 r_ferr;

  // Two-flop synchronizer, idle-high so reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= bus.rx;
      r_rxs   <= r_sync1;
    end
  end

  uart_bit_timer #(
    .BIT_TIME (BIT_TIME),
    .CNT_W    (CNT_W)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .load (w_load),
    .half (1'b1),
    .tick (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_clr_idx = 1'b0;
    w_shift   = 1'b0;
    w_cap_par = 1'b0;
    w_finish  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_rxs) begin
          w_next = START;
          w_load = 1'b1;
        end
      end
      START: begin
        if (w_tick) begin
          w_clr_idx = 1'b1;
          w_next    = r_rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shift = 1'b1;
          if (r_idx == c_last_idx) begin
            w_next = bus.pen ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (w_tick) begin
          w_cap_par = 1'b1;
          w_next    = STOP;
        end
      end
      STOP: begin
        if (w_tick) begin
          w_finish = 1'b1;
          // Returning at mid-stop lets a back-to-back start edge be seen.
          w_next   = r_rxs ? IDLE : WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (r_rxs) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx     <= '0;
      r_shreg   <= '0;
      r_pbit    <= 1'b0;
      r_rx_data <= '0;
      r_rx_done <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_rx_done <= w_finish;
      if (w_clr_idx) begin
        r_idx <= '0;
      end else if (w_shift) begin
        r_idx <= r_idx + c_idx_one;
      end
      if (w_shift) begin
        r_shreg <= {r_rxs, r_shreg[DATA_BITS-1:1]};
      end
      if (w_cap_par) begin
        r_pbit <= r_rxs;
      end
      if (w_finish) begin
        r_rx_data <= r_shreg;
        r_ferr    <= ~r_rxs;
        // Odd sense flips the expected XOR of data plus parity from 0 to 1.
        r_perr    <= bus.pen & (^r_shreg ^ r_pbit ^ bus.odd);
      end
    end
  end

  assign bus.rx_data = r_rx_data;
  assign bus.rx_done = r_rx_done;
  assign bus.perr    = r_perr;
  assign bus.ferr    = r_ferr;
  assign bus.busy    = (r_state != IDLE) && (r_state != WAIT_HI);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_rx_engine                                             |
// | Brief    : Scoreboard bench for uart_rx_engine with a frame-level model  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_uart_rx_engine;

  localparam int BT = 16;

  typedef struct {
    logic [7:0] data;
    bit         perr;
    bit         ferr;
    int         start;
    int         pen;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  exp_t sb[$];

  uart_rx_engine_if bus_if ();

  uart_rx_engine #(
    .BIT_TIME (BT),
    .CNT_W    (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  // Parity bit a correct transmitter would send for the current sense.
  function automatic logic good_par(input logic [7:0] d);
    return 1'(($countones(d) + int'(bus_if.odd)) % 2);
  endfunction

  task automatic bit_time(input logic b);
    bus_if.rx = b;
    repeat (BT) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop_b);
    exp_t e;
    e.data  = d;
    e.ferr  = (stop_b == 1'b0);
    e.perr  = (bus_if.pen == 1'b1) &&
              ((($countones(d) + int'(pbit)) % 2) != int'(bus_if.odd));
    e.start = cyc;
    e.pen   = int'(bus_if.pen);
    sb.push_back(e);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    if (bus_if.pen) bit_time(pbit);
    bit_time(stop_b);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    int   lat;
    int   base;
    if (!rst && bus_if.rx_done) begin
      if (sb.size() == 0) begin
        check("unexpected_rx_done", 32'd1, 32'd0);
      end else begin
        e    = sb.pop_front();
        lat  = cyc - e.start;
        base = 2 + BT / 2 + (9 + e.pen) * BT + 1;
        check("rx_data", 32'(bus_if.rx_data), 32'(e.data));
        check("perr", 32'(bus_if.perr), 32'(e.perr));
        check("ferr", 32'(bus_if.ferr), 32'(e.ferr));
        check("latency_window", 32'(lat >= base - 1 && lat <= base + 1), 32'd1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    logic       pb;
    logic       st;
    logic [7:0] held_data;
    logic       held_perr;
    logic       held_ferr;

    bus_if.rx  = 1'b1;
    bus_if.pen = 1'b0;
    bus_if.odd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_data", 32'(bus_if.rx_data), 32'd0);
    check("reset_rx_done", 32'(bus_if.rx_done), 32'd0);
    check("reset_perr", 32'(bus_if.perr), 32'd0);
    check("reset_ferr", 32'(bus_if.ferr), 32'd0);
    check("reset_busy", 32'(bus_if.busy), 32'd0);
    rst = 1'b0;
    repeat (BT) @(posedge clk);
    #1;

    send_frame(8'hA5, 1'b0, 1'b1);
    repeat (2 * BT) @(posedge clk);
    #1;

    bus_if.pen = 1'b1;
    bus_if.odd = 1'b0;
    send_frame(8'h03, 1'b0, 1'b1);
    send_frame(8'h03, 1'b1, 1'b1);
    repeat (BT) @(posedge clk);
    #1;

    bus_if.odd = 1'b1;
    send_frame(8'h7F, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    check("wait_hi_not_busy", 32'(bus_if.busy), 32'd0);
    bus_if.rx = 1'b1;
    repeat (2 * BT) @(posedge clk);
    #1;
    send_frame(8'h11, good_par(8'h11), 1'b1);
    repeat (2 * BT) @(posedge clk);
    #1;

    // Glitch shorter than half a bit while idle.
    bus_if.pen = 1'b0;
    held_data  = bus_if.rx_data;
    held_perr  = bus_if.perr;
    held_ferr  = bus_if.ferr;
    bus_if.rx  = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus_if.rx = 1'b1;
    check("glitch_busy_high", 32'(bus_if.busy), 32'd1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("glitch_busy_cleared", 32'(bus_if.busy), 32'd0);
    check("glitch_rx_data_held", 32'(bus_if.rx_data), 32'(held_data));
    check("glitch_perr_held", 32'(bus_if.perr), 32'(held_perr));
    check("glitch_ferr_held", 32'(bus_if.ferr), 32'(held_ferr));
    @(posedge clk);
    #1;

    send_frame(8'h55, 1'b0, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b1);
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b0);
    bit_time(1'b1);
    bus_if.rx = 1'b0;
    repeat (BT / 2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midframe_rst_rx_data", 32'(bus_if.rx_data), 32'd0);
    check("midframe_rst_rx_done", 32'(bus_if.rx_done), 32'd0);
    check("midframe_rst_perr", 32'(bus_if.perr), 32'd0);
    check("midframe_rst_ferr", 32'(bus_if.ferr), 32'd0);
    check("midframe_rst_busy", 32'(bus_if.busy), 32'd0);
    bus_if.rx = 1'b1;
    repeat (BT) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4 * BT) @(posedge clk);
    #1;
    check("post_rst_idle", 32'(bus_if.busy), 32'd0);
    send_frame(8'h3C, 1'b0, 1'b1);

    for (int n = 0; n < 10; n++) begin
      bus_if.pen = 1'($urandom_range(0, 1));
      bus_if.odd = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      pb = good_par(d) ^ 1'($urandom_range(0, 3) == 0);
      st = 1'($urandom_range(0, 4) != 0);
      send_frame(d, pb, st);
      if (!st) begin
        bus_if.rx = 1'b1;
        repeat (BT) @(posedge clk);
        #1;
      end
      repeat ($urandom_range(0, 20)) @(posedge clk);
      #1;
    end

    for (int i = 0; i < 4 * BT && sb.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
